// File: rtl/iobus_uart_tx.sv
// Memory-mapped UART transmitter: TXDATA/STATUS registers on the I/O bus,
// a small byte FIFO and an 8N1 serializer with a fixed bit period.
module iobus_uart_tx #(
    parameter logic [31:0] BASE_ADDR    = 32'h1100_0040,
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] IOBUS_ADDR,
    input  logic [31:0] IOBUS_OUT,
    input  logic        IOBUS_WR,
    output logic [31:0] IOBUS_IN,
    output logic        TX
);

    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [31:0]       STATUS_ADDR = BASE_ADDR + 32'd4;
    localparam logic [BAUD_W-1:0] BAUD_LAST   = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  DEPTH_CNT   = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t              state;
    logic [BAUD_W-1:0]   baud_cnt;
    logic [2:0]          bit_cnt;
    logic [7:0]          shreg;
    logic                tx_q;

    logic [7:0]          mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    count;
    logic                ovf;

    logic                sel_tx;
    logic                sel_st;
    logic                fifo_full;
    logic                fifo_empty;
    logic                push;
    logic                pop;
    logic                baud_done;
    logic [7:0]          head;
    logic [31:0]         status;
    logic                unused_bits;

    // Bus decode, FIFO handshakes and pop request from the serializer.
    always_comb begin
        sel_tx     = IOBUS_WR && (IOBUS_ADDR == BASE_ADDR);
        sel_st     = IOBUS_WR && (IOBUS_ADDR == STATUS_ADDR);
        fifo_full  = (count == DEPTH_CNT);
        fifo_empty = (count == CNT_W'(0));
        push       = sel_tx && !fifo_full;
        baud_done  = (baud_cnt == BAUD_LAST);
        pop        = !fifo_empty &&
                     ((state == ST_IDLE) || ((state == ST_STOP) && baud_done));
        head       = mem[rd_ptr];
    end

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge CLK) begin
        if (!RST && push) begin
            mem[wr_ptr] <= IOBUS_OUT[7:0];
        end
    end

    // FIFO pointers and occupancy; a full-FIFO push is dropped even if a pop frees a slot.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky overflow flag, cleared only by writing STATUS with bit 3 set.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ovf <= 1'b0;
        end else if (sel_tx && fifo_full) begin
            ovf <= 1'b1;
        end else if (sel_st && IOBUS_OUT[3]) begin
            ovf <= 1'b0;
        end
    end

    // Serializer FSM: start bit, 8 data bits LSB first, stop bit, back-to-back when queued.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            tx_q     <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    tx_q     <= 1'b1;
                    baud_cnt <= '0;
                    if (pop) begin
                        state   <= ST_START;
                        shreg   <= head;
                        bit_cnt <= '0;
                        tx_q    <= 1'b0;
                    end
                end
                ST_START: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        tx_q     <= shreg[0];
                        shreg    <= {1'b0, shreg[7:1]};
                        state    <= ST_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                ST_DATA: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        if (bit_cnt == 3'd7) begin
                            bit_cnt <= '0;
                            tx_q    <= 1'b1;
                            state   <= ST_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            tx_q    <= shreg[0];
                            shreg   <= {1'b0, shreg[7:1]};
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                ST_STOP: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        if (pop) begin
                            state   <= ST_START;
                            shreg   <= head;
                            bit_cnt <= '0;
                            tx_q    <= 1'b0;
                        end else begin
                            state <= ST_IDLE;
                            tx_q  <= 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    tx_q  <= 1'b1;
                end
            endcase
        end
    end

    // STATUS layout and read mux; reads return zero off-address so buses can OR-combine.
    always_comb begin
        status        = '0;
        status[0]     = fifo_full;
        status[1]     = fifo_empty;
        status[2]     = (state != ST_IDLE);
        status[3]     = ovf;
        status[11:8]  = 4'(count);
        IOBUS_IN      = (IOBUS_ADDR == STATUS_ADDR) ? status : 32'h0;
    end

    assign TX          = tx_q;
    assign unused_bits = ^IOBUS_OUT[31:8];

endmodule

// File: tb/tb_iobus_uart_tx.sv
// Scoreboard bench for iobus_uart_tx: a cycle-level occupancy model predicts
// accepted bytes and frame start edges; a serial monitor decodes TX and checks.
module tb_iobus_uart_tx;

    localparam logic [31:0] BASE  = 32'h1100_0040;
    localparam logic [31:0] STAT  = BASE + 32'd4;
    localparam int          CPB   = 4;
    localparam int          DEPTH = 8;
    localparam int          FRAME = 10 * CPB;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr = 32'h0;
    logic [31:0] dout = 32'h0;
    logic        wr = 1'b0;
    logic [31:0] iobus_in;
    logic        tx;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [7:0] mq[$];      // bytes held in the FIFO
    logic [7:0] exp_q[$];   // bytes expected on the line, in order
    int         pop_q[$];   // edge numbers at which a frame must start
    int         tx_rem = 0; // cycles left in the frame being sent
    logic       m_ovf = 1'b0;
    int         edge_n = 0;

    // Monitor state
    logic       mon_on = 1'b0;
    int         mon_pos = 0;
    logic       shape_ok = 1'b1;
    logic [7:0] rx_byte = 8'h0;

    iobus_uart_tx #(
        .BASE_ADDR   (BASE),
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .CLK       (clk),
        .RST       (rst),
        .IOBUS_ADDR(addr),
        .IOBUS_OUT (dout),
        .IOBUS_WR  (wr),
        .IOBUS_IN  (iobus_in),
        .TX        (tx)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_status();
        logic [31:0] s;
        s        = 32'h0;
        s[0]     = (mq.size() == DEPTH);
        s[1]     = (mq.size() == 0);
        s[2]     = (tx_rem != 0);
        s[3]     = m_ovf;
        s[11:8]  = 4'(mq.size());
        return s;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        return (a == STAT) ? model_status() : 32'h0;
    endfunction

    // Model: one step per rising edge, using the bus values presented before it.
    always @(posedge clk) begin
        edge_n++;
        if (rst) begin
            mq.delete();
            exp_q.delete();
            pop_q.delete();
            tx_rem = 0;
            m_ovf  = 1'b0;
        end else begin
            logic full_before;
            full_before = (mq.size() == DEPTH);
            if (tx_rem <= 1 && mq.size() > 0) begin
                void'(mq.pop_front());
                pop_q.push_back(edge_n);
                tx_rem = FRAME;
            end else if (tx_rem > 0) begin
                tx_rem--;
            end
            if (wr && addr == BASE) begin
                if (full_before) begin
                    m_ovf = 1'b1;
                end else begin
                    mq.push_back(dout[7:0]);
                    exp_q.push_back(dout[7:0]);
                end
            end
            if (wr && addr == STAT && dout[3]) m_ovf = 1'b0;
        end
    end

    // Monitor: decode the serial line and compare each frame with the scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            mon_on = 1'b0;
        end else begin
            if (!mon_on && tx === 1'b0) begin
                mon_on   = 1'b1;
                mon_pos  = 0;
                shape_ok = 1'b1;
                rx_byte  = 8'h0;
                if (pop_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_start: frame began at edge %0d with none predicted", edge_n);
                end else begin
                    check("start_edge", edge_n, pop_q.pop_front());
                end
            end
            if (mon_on) begin
                int bitn;
                int ph;
                bitn = mon_pos / CPB;
                ph   = mon_pos % CPB;
                if (bitn == 0) begin
                    if (tx !== 1'b0) shape_ok = 1'b0;
                end else if (bitn == 9) begin
                    if (tx !== 1'b1) shape_ok = 1'b0;
                end else if (ph == 0) begin
                    rx_byte[bitn-1] = tx;
                end else if (tx !== rx_byte[bitn-1]) begin
                    shape_ok = 1'b0;
                end
                mon_pos++;
                if (mon_pos == FRAME) begin
                    mon_on = 1'b0;
                    check("frame_shape", {31'h0, shape_ok}, 32'h1);
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_byte: got %h with nothing expected", rx_byte);
                    end else begin
                        check("rx_byte", {24'h0, rx_byte}, {24'h0, exp_q.pop_front()});
                    end
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        wr   = 1'b1;
        addr = a;
        dout = d;
        @(posedge clk);
        #1;
        wr   = 1'b0;
        addr = 32'h0;
    endtask

    task automatic read_exp(input logic [31:0] a, input string name, input logic [31:0] exp);
        addr = a;
        @(negedge clk);
        check(name, iobus_in, exp);
        check({name, "_model"}, iobus_in, model_read(a));
        @(posedge clk);
        #1;
    endtask

    task automatic read_model(input logic [31:0] a, input string name);
        addr = a;
        @(negedge clk);
        check(name, iobus_in, model_read(a));
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] alist [6];
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset values
        check("reset_tx", {31'h0, tx}, 32'h1);
        read_exp(STAT, "reset_status", 32'h0000_0002);
        read_exp(BASE, "reset_txdata_read", 32'h0);

        // Single frame and BUSY window
        bus_write(BASE, 32'hFFFF_FFA5);
        read_exp(BASE, "busy_txdata_read", 32'h0);
        idle(38);
        read_exp(STAT, "busy_mid", 32'h0000_0006);
        read_exp(STAT, "busy_last", 32'h0000_0006);
        read_exp(STAT, "idle_after_frame", 32'h0000_0002);
        idle(5);

        // Burst of ten writes overflows the FIFO
        for (int i = 0; i < 10; i++) bus_write(BASE, 32'(i));
        read_exp(STAT, "burst_status", 32'h0000_080D);
        bus_write(STAT, 32'h0);
        read_exp(STAT, "ovf_kept", 32'h0000_080D);
        bus_write(STAT, 32'h8);
        read_exp(STAT, "ovf_cleared", 32'h0000_0805);
        idle(9 * FRAME);
        read_exp(STAT, "burst_drained", 32'h0000_0002);

        // Reset in the middle of DATA bit 3 with three bytes queued
        for (int i = 0; i < 4; i++) bus_write(BASE, 32'h30 + 32'(i));
        idle(14);
        pulse_reset();
        check("abort_tx", {31'h0, tx}, 32'h1);
        read_exp(STAT, "abort_status", 32'h0000_0002);
        idle(100);
        check("abort_discard", 32'(exp_q.size()), 32'h0);

        // Undecoded addresses
        bus_write(BASE + 32'd8, 32'h55);
        bus_write(BASE + 32'd1, 32'h66);
        read_exp(BASE + 32'd8, "read_base8", 32'h0);
        read_exp(BASE + 32'd1, "read_base1", 32'h0);
        read_exp(STAT, "fifo_untouched", 32'h0000_0002);
        idle(FRAME);

        // Randomized traffic against the model
        alist[0] = BASE;
        alist[1] = STAT;
        alist[2] = BASE + 32'd8;
        alist[3] = BASE + 32'd1;
        alist[4] = BASE - 32'd4;
        for (int it = 0; it < 300; it++) begin
            int op;
            alist[5] = $urandom;
            op = $urandom_range(0, 9);
            if (op <= 3) begin
                int n;
                n = $urandom_range(1, 5);
                for (int k = 0; k < n; k++) bus_write(BASE, $urandom);
            end else if (op == 4) begin
                bus_write(STAT, $urandom);
            end else if (op == 5) begin
                bus_write(alist[$urandom_range(2, 5)], $urandom);
            end else if (op == 6) begin
                read_model(alist[$urandom_range(0, 5)], "rand_read");
            end else if (op == 7) begin
                idle($urandom_range(0, 60));
            end else if (op == 8) begin
                read_model(STAT, "rand_status");
            end else if ($urandom_range(0, 3) == 0) begin
                pulse_reset();
                check("rand_reset_tx", {31'h0, tx}, 32'h1);
            end
        end

        // Drain everything still queued
        for (int i = 0; i < 3000 && (exp_q.size() != 0 || mon_on); i++) idle(1);
        check("drain_empty", 32'(exp_q.size()), 32'h0);
        idle(2);
        read_model(STAT, "final_status");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
